switch_packetizer: RTL and testbench

Switch-to-NoC ingress adapter. It accepts dual-beat Avalon-ST words from a switch-fabric port, 142 bits per word carrying two 64-bit beats. It packs up to four consecutive words of one packet into the four 150-bit slots of a 600-bit NoC flit, stamps each slot with head/tail/destination/VC, and presents the flit on a valid/ready interface. Its flit and slot layouts are exactly those the fabric egress depacketizer unpacks, so a packetizer→NoC→depacketizer path reproduces the original word stream.

---
 rtl/switch_packetizer.sv | 185 ++++++++++++++++++
 tb/tb_switch_packetizer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_packetizer.sv
// Packs dual-beat switch words into 4-slot NoC flits with head/tail/dest/vc.
// SWITCH_PACKETIZER_DROP_CNT_EN enables the saturating headless-word counter.
module switch_packetizer #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 142,
    parameter int WIDTH_OUT        = 600
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH_IN-1:0]         i_data_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    input  logic [ADDRESS_WIDTH-1:0]    i_dest,
    input  logic [VC_ADDRESS_WIDTH-1:0] i_vc,
    output logic [WIDTH_OUT-1:0]        o_data_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in,
    output logic [15:0]                 o_drop_cnt
);
    localparam int S   = WIDTH_OUT / 4;
    localparam int H   = WIDTH_IN / 2;
    localparam int PAD = S - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH
                         - 2 * (DATA_WIDTH + 5);

    typedef enum logic {IDLE, ASM} state_t;
    typedef logic [0:3][S-1:0] flit_t;

    state_t                      state_q, state_n;
    logic [1:0]                  ptr_q, ptr_n, last;
    flit_t                       asm_q, asm_n, tmp, fresh;
    flit_t                       flit_a, flit_b, flit_out;
    logic                        hold_q, hold_n;
    logic [ADDRESS_WIDTH-1:0]    dest_q, dest_n;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_n;
    logic                        emit_a, emit_b, load, drop, accept;

    logic [H-1:0]            h0, h1;
    logic                    sop0, eop0, err0, keep1, eop1, err1, eop_w;
    logic [2:0]              empty0, empty1;
    logic [DATA_WIDTH-1:0]   data0, data1;
    logic [S-1:0]            slot_w;
    logic                    unused_bits;

    assign h0     = i_data_in[2*H-1 -: H];
    assign h1     = i_data_in[H-1:0];
    assign sop0   = h0[H-2];
    assign eop0   = h0[H-3];
    assign empty0 = h0[H-4 -: 3];
    assign err0   = h0[H-7];
    assign data0  = h0[DATA_WIDTH-1:0];
    // Half 1 only carries data when valid and half 0 did not end the packet
    assign keep1  = h1[H-1] & ~eop0;
    assign eop1   = keep1 & h1[H-3];
    assign empty1 = keep1 ? h1[H-4 -: 3] : 3'd0;
    assign err1   = keep1 & h1[H-7];
    assign data1  = keep1 ? h1[DATA_WIDTH-1:0] : '0;
    assign eop_w  = eop0 | eop1;
    assign unused_bits = ^{h0[H-1], h1[H-2]};

    assign slot_w = {1'b1, sop0, eop_w,
                     sop0 ? i_dest : dest_q,
                     sop0 ? i_vc : vc_q,
                     eop0, empty0, err0, data0,
                     eop1, empty1, err1, data1,
                     {PAD{1'b0}}};

    assign i_ready_out = !o_valid_out || o_ready_in;
    assign accept      = i_valid_in && i_ready_out;
    assign last        = ptr_q - 2'd1;

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        asm_n   = asm_q;
        hold_n  = hold_q;
        dest_n  = dest_q;
        vc_n    = vc_q;
        emit_a  = 1'b0;
        emit_b  = 1'b0;
        flit_a  = '0;
        flit_b  = '0;
        drop    = 1'b0;
        tmp     = asm_q;
        fresh   = '0;
        // A parked flit leaves first whenever the output can load
        if (i_ready_out && hold_q) begin
            emit_a = 1'b1;
            flit_a = asm_q;
            asm_n  = '0;
            hold_n = 1'b0;
        end
        if (accept) begin
            if (sop0) begin
                dest_n = i_dest;
                vc_n   = i_vc;
                if (state_q == ASM && ptr_q != 2'd0) begin
                    tmp[last][S-3] = 1'b1;
                    emit_a = 1'b1;
                    flit_a = tmp;
                end
                fresh[0] = slot_w;
                if (eop_w) begin
                    emit_b  = 1'b1;
                    flit_b  = fresh;
                    asm_n   = '0;
                    ptr_n   = 2'd0;
                    state_n = IDLE;
                end else begin
                    asm_n   = fresh;
                    ptr_n   = 2'd1;
                    state_n = ASM;
                end
            end else if (state_q == ASM) begin
                tmp[ptr_q] = slot_w;
                if (ptr_q == 2'd3 || eop_w) begin
                    emit_b  = 1'b1;
                    flit_b  = tmp;
                    asm_n   = '0;
                    ptr_n   = 2'd0;
                    state_n = eop_w ? IDLE : ASM;
                end else begin
                    asm_n = tmp;
                    ptr_n = ptr_q + 2'd1;
                end
            end else begin
                drop = 1'b1;
            end
        end
        load     = emit_a | emit_b;
        flit_out = emit_a ? flit_a : flit_b;
        // Two flits finished together: park the second one in the assembly
        if (emit_a && emit_b) begin
            asm_n  = flit_b;
            hold_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            asm_q       <= '0;
            hold_q      <= 1'b0;
            dest_q      <= '0;
            vc_q        <= '0;
            o_valid_out <= 1'b0;
            o_data_out  <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            asm_q   <= asm_n;
            hold_q  <= hold_n;
            dest_q  <= dest_n;
            vc_q    <= vc_n;
            if (load) begin
                o_valid_out <= 1'b1;
                o_data_out  <= flit_out;
            end else if (o_ready_in) begin
                o_valid_out <= 1'b0;
            end
        end
    end

`ifdef SWITCH_PACKETIZER_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 16'd0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign o_drop_cnt = drop_q;
`else
    logic unused_drop;

    assign unused_drop = drop;
    assign o_drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_switch_packetizer.sv
// Directed bench for switch_packetizer: flit layout, stalls, drops, reset.
module tb_switch_packetizer;
    logic         clk = 1'b0;
    logic         reset;
    logic [141:0] i_data_in;
    logic         i_valid_in;
    logic         i_ready_out;
    logic [3:0]   i_dest;
    logic [0:0]   i_vc;
    logic [599:0] o_data_out;
    logic         o_valid_out;
    logic         o_ready_in;
    logic [15:0]  o_drop_cnt;

    switch_packetizer dut (
        .clk(clk),
        .reset(reset),
        .i_data_in(i_data_in),
        .i_valid_in(i_valid_in),
        .i_ready_out(i_ready_out),
        .i_dest(i_dest),
        .i_vc(i_vc),
        .o_data_out(o_data_out),
        .o_valid_out(o_valid_out),
        .o_ready_in(o_ready_in),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    logic [599:0] fq[$];

    always @(negedge clk)
        if (!reset && o_valid_out && o_ready_in)
            fq.push_back(o_data_out);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [141:0] mk(
        input logic s0, input logic e0, input logic [2:0] em0,
        input logic er0, input logic [63:0] d0,
        input logic v1, input logic e1, input logic [2:0] em1,
        input logic er1, input logic [63:0] d1);
        return {1'b1, s0, e0, em0, er0, d0, v1, 1'b0, e1, em1, er1, d1};
    endfunction

    function automatic logic [149:0] sl(input logic [599:0] f,
                                        input int j);
        return f[(4-j)*150-1 -: 150];
    endfunction

    function automatic logic [3:0] bits(input logic [599:0] f,
                                        input int b);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) r[3-j] = f[(4-j)*150-1-b];
        return r;
    endfunction

    function automatic logic [15:0] dests(input logic [599:0] f);
        logic [15:0] r;
        for (int j = 0; j < 4; j++) r[15-4*j -: 4] = sl(f, j)[146:143];
        return r;
    endfunction

    task automatic drv(input logic [141:0] w, input logic [3:0] d,
                       input logic v);
        @(posedge clk);
        #2;
        i_data_in  = w;
        i_valid_in = 1'b1;
        i_dest     = d;
        i_vc       = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            i_valid_in = 1'b0;
        end
    endtask

    logic [599:0] f, saved;
    logic [149:0] s;

    initial begin
        reset      = 1'b1;
        i_data_in  = '0;
        i_valid_in = 1'b0;
        i_dest     = '0;
        i_vc       = '0;
        o_ready_in = 1'b1;
        #12;
        chk("rst_valid", o_valid_out, 1'b0);
        chk("rst_data", o_data_out == '0, 1'b1);
        chk("rst_drop", o_drop_cnt, 16'd0);
        chk("rst_ready", i_ready_out, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // single-word packet
        drv(mk(1, 1, 0, 0, 64'hA5, 0, 0, 0, 0, 0), 4'd3, 1'b1);
        @(posedge clk);
        #1;
        chk("t1_lat", o_valid_out, 1'b1);
        i_valid_in = 1'b0;
        idle(2);
        chk("t1_cnt", fq.size(), 1);
        f = fq.pop_front();
        s = sl(f, 0);
        chk("t1_vht", s[149:147], 3'b111);
        chk("t1_dest", s[146:143], 4'd3);
        chk("t1_vc", s[142], 1'b1);
        chk("t1_d0", s[136:73], 64'hA5);
        chk("t1_rest", f[449:0] == '0, 1'b1);

        // four-word packet
        for (int i = 1; i <= 4; i++)
            drv(mk(i == 1, 0, 0, 0, 64'(2*i-1),
                   1, i == 4, i == 4 ? 3'd2 : 3'd0, 0, 64'(2*i)),
                4'd2, 1'b0);
        idle(3);
        chk("t2_cnt", fq.size(), 1);
        f = fq.pop_front();
        chk("t2_valid", bits(f, 0), 4'b1111);
        chk("t2_head", bits(f, 1), 4'b1000);
        chk("t2_tail", bits(f, 2), 4'b0001);
        chk("t2_dest", dests(f), 16'h2222);
        s = sl(f, 3);
        chk("t2_h1", {s[72], s[71:69], s[67:4]}, {1'b1, 3'd2, 64'd8});
        chk("t2_d0s2", sl(f, 2)[136:73], 64'd5);

        // six-word packet, eop0 on word 6 masks half 1
        for (int i = 1; i <= 6; i++)
            drv(mk(i == 1, i == 6, 0, 0, 64'(i*16),
                   1, i == 6, 3'd5, i == 6, 64'hFFFF), 4'd7, 1'b1);
        idle(3);
        chk("t3_cnt", fq.size(), 2);
        f = fq.pop_front();
        chk("t3a_valid", bits(f, 0), 4'b1111);
        chk("t3a_tail", bits(f, 2), 4'b0000);
        chk("t3a_d1", sl(f, 3)[67:4], 64'hFFFF);
        f = fq.pop_front();
        chk("t3b_valid", bits(f, 0), 4'b1100);
        chk("t3b_head", bits(f, 1), 4'b0000);
        chk("t3b_tail", bits(f, 2), 4'b0100);
        s = sl(f, 1);
        chk("t3b_h1", {s[72:4]} == '0, 1'b1);
        chk("t3b_d0", s[136:73], 64'h60);
        chk("t3b_zero", f[299:0] == '0, 1'b1);

        // output stall while a full flit is pending
        o_ready_in = 1'b0;
        for (int i = 1; i <= 4; i++)
            drv(mk(i == 1, 0, 0, 0, 64'(i), 1, i == 4, 0, 0, 64'(i)),
                4'd1, 1'b0);
        drv(mk(1, 1, 0, 0, 64'hBB, 0, 0, 0, 0, 0), 4'd4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) saved = o_data_out;
            else chk("t4_stable", o_data_out == saved, 1'b1);
            chk("t4_rdy0", i_ready_out, 1'b0);
            chk("t4_vld", o_valid_out, 1'b1);
        end
        chk("t4_none", fq.size(), 0);
        @(posedge clk);
        #2;
        o_ready_in = 1'b1;
        #1;
        chk("t4_rdy1", i_ready_out, 1'b1);
        idle(3);
        chk("t4_cnt", fq.size(), 2);
        f = fq.pop_front();
        chk("t4a_dest", dests(f), 16'h1111);
        chk("t4a_valid", bits(f, 0), 4'b1111);
        f = fq.pop_front();
        chk("t4b_vht", sl(f, 0)[149:147], 3'b111);
        chk("t4b_dest", sl(f, 0)[146:143], 4'd4);
        chk("t4b_d0", sl(f, 0)[136:73], 64'hBB);

        // headless word in IDLE
        drv(mk(0, 1, 0, 0, 64'h77, 0, 0, 0, 0, 0), 4'd2, 1'b0);
        idle(3);
        chk("t5_none", fq.size(), 0);
`ifdef SWITCH_PACKETIZER_DROP_CNT_EN
        chk("t5_drop", o_drop_cnt, 16'd1);
`else
        chk("t5_drop", o_drop_cnt, 16'd0);
`endif

        // sop arrives after two words without eop
        drv(mk(1, 0, 0, 0, 64'h1, 1, 0, 0, 0, 64'h2), 4'd5, 1'b0);
        drv(mk(0, 0, 0, 0, 64'h3, 1, 0, 0, 0, 64'h4), 4'd5, 1'b0);
        drv(mk(1, 0, 0, 0, 64'h5, 1, 0, 0, 0, 64'h6), 4'd9, 1'b1);
        drv(mk(0, 1, 0, 0, 64'h7, 0, 0, 0, 0, 0), 4'd0, 1'b0);
        idle(3);
        chk("t6_cnt", fq.size(), 2);
        f = fq.pop_front();
        chk("t6a_valid", bits(f, 0), 4'b1100);
        chk("t6a_tail", bits(f, 2), 4'b0100);
        chk("t6a_dest", dests(f), 16'h5500);
        f = fq.pop_front();
        chk("t6b_valid", bits(f, 0), 4'b1100);
        chk("t6b_head", bits(f, 1), 4'b1000);
        chk("t6b_tail", bits(f, 2), 4'b0100);
        chk("t6b_dest", dests(f), 16'h9900);
        chk("t6b_vc", bits(f, 7), 4'b1100);

        // reset while a flit is held and another is pending
        o_ready_in = 1'b0;
        drv(mk(1, 0, 0, 0, 64'h11, 1, 0, 0, 0, 64'h12), 4'd5, 1'b0);
        drv(mk(1, 1, 0, 0, 64'h13, 0, 0, 0, 0, 0), 4'd6, 1'b0);
        @(posedge clk);
        #1;
        chk("t7_held", o_valid_out, 1'b1);
        #2;
        reset      = 1'b1;
        i_valid_in = 1'b0;
        #1;
        chk("t7_valid", o_valid_out, 1'b0);
        chk("t7_data", o_data_out == '0, 1'b1);
        chk("t7_drop", o_drop_cnt, 16'd0);
        #5;
        reset      = 1'b0;
        o_ready_in = 1'b1;
        idle(4);
        chk("t7_none", fq.size(), 0);
        chk("t7_vld", o_valid_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
